// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and pattern constants for the ALU sequencer.
package alu_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADDC     = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ADD      = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LOGIC    = OP_W'(2);
  localparam logic [OP_W-1:0] OP_ANY      = OP_W'(3);
  localparam logic [OP_W-1:0] OP_PATTERN  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SWAP_INV = OP_W'(5);
  localparam logic [OP_W-1:0] OP_MUL      = OP_W'(6);
  localparam logic [OP_W-1:0] OP_ACC      = OP_W'(7);

  // Set-bit counts that make the pattern op pass on A and B respectively.
  localparam int unsigned PATTERN_ONES_A = 1;
  localparam int unsigned PATTERN_ONES_B = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/result bus between the switch/key front end and the sequencer.
interface alu_op_sequencer_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
);
  logic                  start;
  logic [OP_W-1:0]       op;
  logic [WIDTH-1:0]      a;
  logic [WIDTH-1:0]      b;
  logic                  cin;
  logic                  acc_clr;
  logic                  busy;
  logic                  done;
  logic [2*WIDTH-1:0]    result;
  logic [2*WIDTH-1:0]    acc;

  modport master (
    output start, op, a, b, cin, acc_clr,
    input  busy, done, result, acc
  );

  modport slave (
    input  start, op, a, b, cin, acc_clr,
    output busy, done, result, acc
  );
endinterface

// File: rtl/alu_core.sv
// Combinational single-cycle ALU function set; multiply is iterated by the sequencer.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cin,
  input  logic [OP_W-1:0]    op,
  input  logic [2*WIDTH-1:0] acc,
  output logic [2*WIDTH-1:0] y
);
  localparam int unsigned RW = 2 * WIDTH;

  // Operation select; multiply yields zero here since it is sequenced elsewhere.
  always_comb begin
    y = '0;
    case (op)
      OP_ADDC:     y = RW'(a) + RW'(b) + RW'(cin);
      OP_ADD:      y = RW'(a) + RW'(b);
      OP_LOGIC:    y = {~(a & b), a ^ b};
      OP_ANY:      y = ((|a) || (|b)) ? RW'(8'h0F) : '0;
      OP_PATTERN:  y = (($countones(a) == PATTERN_ONES_A) &&
                        ($countones(b) == PATTERN_ONES_B)) ? {b, a} : '0;
      OP_SWAP_INV: y = {b, ~a};
      OP_ACC:      y = acc + RW'(a);
      default:     y = '0;
    endcase
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// Handshaked ALU controller: captures a request, runs it, holds result and accumulator.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clock,
  input  logic               resetn,
  alu_op_sequencer_if.slave  bus
);
  localparam int unsigned RW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              cin_q, cin_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [RW-1:0]     partial_q, partial_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [RW-1:0]     result_q, result_d, acc_q, acc_d;
  logic [RW-1:0]     core_y, addend;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a   (a_q),
    .b   (b_q),
    .cin (cin_q),
    .op  (op_q),
    .acc (acc_q),
    .y   (core_y)
  );

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.acc    = acc_q;

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state and next-register values for the capture/execute/multiply flow.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    cin_d     = cin_q;
    cnt_d     = cnt_q;
    partial_d = partial_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
    acc_d     = acc_q;
    addend    = b_q[cnt_q] ? (RW'(a_q) << cnt_q) : '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.acc_clr) acc_d = '0;
        if (bus.start) begin
          a_d    = bus.a;
          b_d    = bus.b;
          op_d   = bus.op;
          cin_d  = bus.cin;
          busy_d = 1'b1;
          if (bus.op == OP_MUL) begin
            state_d   = ST_MUL;
            cnt_d     = '0;
            partial_d = '0;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        result_d = core_y;
        if (op_q == OP_ACC) acc_d = core_y;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_DONE;
      end
      ST_MUL: begin
        partial_d = partial_q + addend;
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          result_d = partial_q + addend;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand, iteration and output registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      cin_q     <= 1'b0;
      cnt_q     <= '0;
      partial_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      acc_q     <= '0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      cin_q     <= cin_d;
      cnt_q     <= cnt_d;
      partial_q <= partial_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      acc_q     <= acc_d;
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: vector table, directed corners, random vs model.
module tb_alu_op_sequencer;
  localparam int unsigned WIDTH = 4;

  logic clock;
  logic resetn;

  alu_op_sequencer_if #(.WIDTH(WIDTH)) bus ();

  alu_op_sequencer #(.WIDTH(WIDTH)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int model_acc = 0;

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int ones4(input int v);
    int n = 0;
    for (int i = 0; i < 4; i++) n += (v >> i) & 1;
    return n;
  endfunction

  // Reference behaviour from the opcode table, plain integer arithmetic.
  function automatic int ref_fn(input int op, input int a, input int b, input int cin, input int acc);
    case (op)
      0: return a + b + cin;
      1: return a + b;
      2: return ((15 - (a & b)) * 16) + (a ^ b);
      3: return ((a != 0) || (b != 0)) ? 15 : 0;
      4: return ((ones4(a) == 1) && (ones4(b) == 2)) ? (b * 16 + a) : 0;
      5: return b * 16 + (15 - a);
      6: return a * b;
      default: return (acc + a) % 256;
    endcase
  endfunction

  // One full request: issue, wait for done, compare with the model, see return to idle.
  task automatic do_op(input int op, input int a, input int b, input int cin, input bit clr,
                       output int got);
    int exp;
    int exp_lat;
    int lat;
    bit seen;
    if (clr) model_acc = 0;
    exp = ref_fn(op, a, b, cin, model_acc) % 256;
    if (op == 7) model_acc = exp;
    exp_lat = (op == 6) ? WIDTH : 1;
    @(negedge clock);
    bus.start = 1'b1; bus.op = 3'(op); bus.a = 4'(a); bus.b = 4'(b);
    bus.cin = 1'(cin); bus.acc_clr = clr;
    @(posedge clock); #1;
    bus.start = 1'b0; bus.acc_clr = 1'b0;
    check("busy_after_start", int'(bus.busy), 1);
    lat = 0; seen = 1'b0;
    while (lat < 20 && !seen) begin
      @(posedge clock); #1;
      lat++;
      if (bus.done) seen = 1'b1;
    end
    check("done_seen", int'(seen), 1);
    check("latency", lat, exp_lat);
    check("result", int'(bus.result), exp);
    check("acc", int'(bus.acc), model_acc);
    check("busy_at_done", int'(bus.busy), 0);
    got = int'(bus.result);
    @(posedge clock); #1;
    check("done_pulse_end", int'(bus.done), 0);
  endtask

  initial begin
    int got;
    int dones;
    bit seen;
    int lat;

    vecs[0]  = '{3'd0, 4'hF, 4'h1, 1'b1, 8'h11};
    vecs[1]  = '{3'd0, 4'hF, 4'hF, 1'b1, 8'h1F};
    vecs[2]  = '{3'd1, 4'hF, 4'hF, 1'b1, 8'h1E};
    vecs[3]  = '{3'd6, 4'hD, 4'hB, 1'b0, 8'h8F};
    vecs[4]  = '{3'd6, 4'h0, 4'hB, 1'b0, 8'h00};
    vecs[5]  = '{3'd6, 4'hF, 4'hF, 1'b0, 8'hE1};
    vecs[6]  = '{3'd4, 4'h4, 4'h6, 1'b0, 8'h64};
    vecs[7]  = '{3'd4, 4'h4, 4'h7, 1'b0, 8'h00};
    vecs[8]  = '{3'd2, 4'hC, 4'hA, 1'b0, 8'h76};
    vecs[9]  = '{3'd3, 4'h0, 4'h0, 1'b0, 8'h00};
    vecs[10] = '{3'd3, 4'h0, 4'h1, 1'b0, 8'h0F};
    vecs[11] = '{3'd5, 4'h3, 4'h9, 1'b0, 8'h9C};

    resetn = 1'b0;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.acc_clr = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_result", int'(bus.result), 0);
    check("rst_acc", int'(bus.acc), 0);
    @(negedge clock); resetn = 1'b1;
    dones = 0;
    repeat (10) begin
      @(posedge clock); #1;
      if (bus.done) dones++;
    end
    check("idle_no_done", dones, 0);

    // Table of spec vectors.
    for (int i = 0; i < 12; i++) begin
      do_op(int'(vecs[i].op), int'(vecs[i].a), int'(vecs[i].b), int'(vecs[i].cin), 1'b0, got);
      check("vec_result", got, int'(vecs[i].exp));
    end

    // Accumulator: clear in idle, seventeen adds of F, then wrap.
    @(negedge clock); bus.acc_clr = 1'b1;
    @(posedge clock); #1; bus.acc_clr = 1'b0;
    model_acc = 0;
    check("acc_clr_idle", int'(bus.acc), 0);
    for (int i = 0; i < 17; i++) do_op(7, 15, 0, 0, 1'b0, got);
    check("acc_ff", int'(bus.acc), 8'hFF);
    do_op(7, 15, 0, 0, 1'b0, got);
    check("acc_wrap", int'(bus.acc), 8'h0E);
    do_op(7, 3, 0, 0, 1'b1, got);
    check("acc_clr_add", int'(bus.acc), 8'h03);

    // Start held through multiply with inputs changing mid-run: exactly one done.
    @(negedge clock);
    bus.start = 1'b1; bus.op = 3'd6; bus.a = 4'hD; bus.b = 4'hB; bus.cin = 1'b0;
    @(posedge clock); #1;
    bus.op = 3'd0; bus.a = 4'h1; bus.b = 4'h1;
    dones = 0; seen = 1'b0; lat = 0;
    while (lat < 20 && !seen) begin
      @(posedge clock); #1;
      lat++;
      if (bus.done) begin seen = 1'b1; dones++; end
    end
    bus.start = 1'b0;
    check("hold_latency", lat, WIDTH);
    check("hold_result", int'(bus.result), 8'h8F);
    repeat (8) begin
      @(posedge clock); #1;
      if (bus.done) dones++;
    end
    check("hold_one_done", dones, 1);
    check("hold_acc", int'(bus.acc), model_acc);

    // Randomized requests against the model.
    for (int i = 0; i < 200; i++) begin
      do_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), got);
    end

    // Reset during multiply aborts it.
    do_op(6, 13, 11, 0, 1'b0, got);
    @(negedge clock);
    bus.start = 1'b1; bus.op = 3'd6; bus.a = 4'hD; bus.b = 4'hB;
    @(posedge clock); #1; bus.start = 1'b0;
    repeat (2) @(posedge clock);
    #1 resetn = 1'b0;
    #1;
    check("abort_result", int'(bus.result), 0);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_acc", int'(bus.acc), 0);
    model_acc = 0;
    @(negedge clock); resetn = 1'b1;
    dones = 0;
    repeat (8) begin
      @(posedge clock); #1;
      if (bus.done) dones++;
    end
    check("abort_no_done", dones, 0);
    check("abort_result_held", int'(bus.result), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
